// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory load port, execute redirect and decode-side instruction stream
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [31:0]           instr_pc;
  logic [31:0]           fetch_pc;
  modport master (
    output imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instr, instr_pc, fetch_pc
  );
  modport slave (
    input  imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instr, instr_pc, fetch_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, synchronous-read program memory, JAL predecode and {instr, pc} output FIFO
module fetch_unit #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          BUF_DEPTH  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.slave bus
);
  localparam int         MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int         PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int         CW        = $clog2(BUF_DEPTH + 1) + 1;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]   r_mem [MEM_DEPTH];
  logic [31:0]   r_rdata;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_buf_instr [BUF_DEPTH];
  logic [31:0]   r_buf_pc [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_ret;
  logic          w_jal;
  logic          w_issue;
  logic [31:0]   w_jimm;
  logic [31:0]   w_sel;
  logic [CW-1:0] w_occ;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue decision and address select; a redirect kills the returning word and empties the FIFO,
  // so the occupancy seen by the issue rule is zero in that cycle.
  always_comb begin
    w_valid = r_count != '0;
    w_pop   = w_valid & bus.instr_ready;
    w_ret   = r_inflight & ~bus.redirect_valid;
    w_jal   = w_ret & (r_rdata[6:0] == OP_JAL);
    w_jimm  = {{11{r_rdata[31]}}, r_rdata[31], r_rdata[19:12], r_rdata[20], r_rdata[30:21], 1'b0};
    w_occ   = bus.redirect_valid ? '0 : r_count - CW'(w_pop) + CW'(w_ret);
    w_issue = w_occ < CW'(BUF_DEPTH);
    w_sel   = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) :
              w_jal              ? r_inflight_pc + w_jimm :
                                   r_fetch_pc;
  end

  // Program memory: load port plus one-cycle read of the selected address (old data on collision)
  always_ff @(posedge clk) begin
    if (bus.imem_we) r_mem[bus.imem_waddr] <= bus.imem_wdata;
    r_rdata <= r_mem[w_sel[ADDR_WIDTH+1:2]];
  end

  // Fetch PC and in-flight read tracking; an unissued target is held in the fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_fetch_pc    <= w_issue ? w_sel + 32'd4 : w_sel;
      r_inflight    <= w_issue;
      r_inflight_pc <= w_sel;
    end
  end

  // Output FIFO: enqueue surviving returns, dequeue on handshake, clear on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_ret) begin
        r_buf_instr[r_wr_ptr] <= r_rdata;
        r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
        r_wr_ptr              <= f_inc(r_wr_ptr);
      end
      r_count <= w_occ;
    end
  end

  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_buf_instr[r_rd_ptr];
  assign bus.instr_pc    = r_buf_pc[r_rd_ptr];
  assign bus.fetch_pc    = r_fetch_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch-stream checks against an in-order program-flow model
module tb_fetch_unit;
  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [31:0] RPC   = 32'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();
  fetch_unit #(.ADDR_WIDTH(AW), .BUF_DEPTH(2), .RESET_PC(RPC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] tmem [DEPTH];
  bit          is_jal [DEPTH];
  int          joff [DEPTH];
  int          jal_pcs [5] = '{0, 4, 8, 24, 28};
  logic [31:0] exp_pc, prev_instr, prev_pc;
  bit          prev_stall;
  int          checks = 0, failures = 0;
  int          idle, max_idle, pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6F};
  endfunction

  task automatic seq_word(input int idx);
    logic [31:0] r;
    r = $urandom;
    tmem[idx]   = {r[31:7], 7'h13};
    is_jal[idx] = 1'b0;
    joff[idx]   = 0;
  endtask

  task automatic set_jal(input int idx, input int off);
    tmem[idx]   = enc_jal(off);
    is_jal[idx] = 1'b1;
    joff[idx]   = off;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DEPTH; i++) seq_word(i);
  endtask

  task automatic start_run();
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = i[AW-1:0];
      bus.imem_wdata = tmem[i];
      @(posedge clk);
      #2;
    end
    bus.imem_we = 1'b0;
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_fetch_pc", bus.fetch_pc, RPC);
    rst_n      = 1'b1;
    exp_pc     = RPC;
    prev_stall = 1'b0;
    idle       = 0;
    max_idle   = 0;
    pops       = 0;
  endtask

  task automatic observe();
    int idx;
    if (prev_stall) begin
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_instr", bus.instr, prev_instr);
      chk("hold_pc", bus.instr_pc, prev_pc);
    end
    if (bus.instr_valid && bus.instr_ready) begin
      idx = int'(exp_pc[AW+1:2]);
      chk("stream_pc", bus.instr_pc, exp_pc);
      chk("stream_instr", bus.instr, tmem[idx]);
      pops++;
      exp_pc = is_jal[idx] ? exp_pc + 32'(joff[idx]) : exp_pc + 32'd4;
    end
    idle       = (bus.instr_valid || bus.redirect_valid) ? 0 : idle + 1;
    max_idle   = (idle > max_idle) ? idle : max_idle;
    prev_stall = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
    prev_instr = bus.instr;
    prev_pc    = bus.instr_pc;
    if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
  endtask

  task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rp);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    #1;
    observe();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Sequential stream, first-valid latency, then backpressure
    fill_seq();
    start_run();
    chk("c0_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    chk("c1_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk("seq_valid", bus.instr_valid, 1);
      chk("seq_pc", bus.instr_pc, 32'(k * 4));
      cyc(1, 0, 0);
    end
    chk("bp_head_pc", bus.instr_pc, 32'h20);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("bp_resume_valid", bus.instr_valid, 1);
      cyc(1, 0, 0);
    end

    // JAL predecode with zero bubble
    fill_seq();
    set_jal(2, 16);
    chk("jal_encoding", tmem[2], 32'h0100006F);
    start_run();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("jal_valid", bus.instr_valid, 1);
      chk("jal_pc", bus.instr_pc, 32'(jal_pcs[k]));
      cyc(1, 0, 0);
    end

    // External redirect with unaligned target
    fill_seq();
    start_run();
    for (int k = 0; k < 4; k++) cyc(1, 0, 0);
    cyc(1, 1, 32'h23);
    chk("redir_t1_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    chk("redir_t2_valid", bus.instr_valid, 1);
    chk("redir_t2_pc", bus.instr_pc, 32'h20);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);

    // Redirect in the cycle the JAL returns
    fill_seq();
    set_jal(2, 16);
    start_run();
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);
    cyc(1, 1, 32'h40);
    chk("rj_t1_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    chk("rj_t2_valid", bus.instr_valid, 1);
    chk("rj_t2_pc", bus.instr_pc, 32'h40);
    cyc(1, 0, 0);
    chk("rj_t3_pc", bus.instr_pc, 32'h44);
    cyc(1, 0, 0);

    // Address wrap and asynchronous mid-stream reset
    fill_seq();
    start_run();
    cyc(1, 1, 32'hF8);
    chk("wrap_c1_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    chk("wrap_pc_f8", bus.instr_pc, 32'hF8);
    cyc(1, 0, 0);
    chk("wrap_pc_fc", bus.instr_pc, 32'hFC);
    cyc(1, 0, 0);
    chk("wrap_pc_100", bus.instr_pc, 32'h100);
    chk("wrap_instr_word0", bus.instr, tmem[0]);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("pre_rst_valid", bus.instr_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.instr_valid, 0);
    chk("async_rst_instr", bus.instr, 0);
    chk("async_rst_pc", bus.instr_pc, 0);
    chk("async_rst_fetch_pc", bus.fetch_pc, RPC);
    start_run();
    cyc(1, 0, 0);
    chk("restart_c1_valid", bus.instr_valid, 0);
    cyc(1, 0, 0);
    chk("restart_pc0", bus.instr_pc, RPC);
    cyc(1, 0, 0);
    chk("restart_pc1", bus.instr_pc, RPC + 32'd4);
    cyc(1, 0, 0);

    // Random programs with JALs, random backpressure and random redirects
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 5) == 0) set_jal(i, 4 * int'($urandom_range(0, 31)) - 64);
        else seq_word(i);
      end
      start_run();
      for (int n = 0; n < 300; n++)
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      chk("rand_progress", max_idle <= 3, 1);
      chk("rand_pops", pops > 50, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that replaces the single-cycle PC/program-memory front end. Holds the fetch PC and an internal word-addressed program memory with a one-cycle synchronous read. Predecodes JAL for a zero-bubble jump, accepts branch/JALR redirects from execute, and delivers `{instr, pc}` pairs to decode through a valid/ready FIFO.

## Interface
- `ADDR_WIDTH`, 6: program-memory word-address width; `MEM_DEPTH = 2**ADDR_WIDTH` words.
- `BUF_DEPTH`, 2: output FIFO entries, ≥2.
- `RESET_PC`, 32'h0: fetch PC after reset, word aligned.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_we`  in  1  program-memory write enable, used for loading.
- `imem_waddr`  in  ADDR_WIDTH  word address for writes.
- `imem_wdata`  in  32  write data.
- `redirect_valid`  in  1  execute-stage redirect (taken branch/JALR).
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decode accepts the head.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  32  head instruction byte address.
- `fetch_pc`  out  32  address of the next fetch to issue (debug).

## Operation
- **Reset** (while `reset`=0, asynchronously): FIFO empty, in-flight read cleared, `fetch_pc`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0. Memory contents are not reset.
- **Memory index:** `addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses wrap modulo `MEM_DEPTH*4`.
- **Read timing:** a read issued in cycle N returns data in cycle N+1.
- **Write port:** writes take effect at the clock edge. A read and a write to the same word in the same cycle returns the old data.
- **Issue rule:** a read is issued in a cycle when `occupancy − pop + inflight < BUF_DEPTH`.
  - `pop` = `instr_valid & instr_ready`.
  - `inflight` = a non-killed read returning this cycle.
- **Issue address priority:**
  1. `redirect_valid`: address = `redirect_pc`.
  2. Returning word has opcode 7'b1101111 (JAL): address = returning PC + J-immediate, where J-immediate = sign-extend({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  3. Otherwise: `fetch_pc`.
- **PC update:** `fetch_pc` is set to issued address + 4 when a read issues. When no read issues, it is set to the selected address, so the redirect or JAL target is retained while stalled.
- **Return handling:** a returning, non-killed word is enqueued with its PC. A JAL is itself enqueued.
- **External redirect:** flushes the FIFO and kills the in-flight read, both at the same edge. It has priority over a simultaneous JAL predecode, and the killed word is never enqueued. A pop in the same cycle is still a valid handshake.
- **Output stability:** while `instr_valid & !instr_ready`, `instr` and `instr_pc` hold stable.

## Timing
- First `instr_valid` appears 2 cycles after `reset` deasserts (issue in cycle 0, return in cycle 1, visible in cycle 2).
- With `instr_ready`=1 and `BUF_DEPTH`≥2, throughput is one instruction per cycle.
- JAL costs zero bubbles: the target word directly follows the JAL in the stream.
- External redirect asserted in cycle T:
  - `instr_valid`=0 in cycle T+1.
  - The target instruction is valid in cycle T+2.
  - Penalty is 2 cycles.
- Backpressure never drops or duplicates an instruction. Once `instr_ready` rises, the stream resumes in order with no gap when the FIFO is non-empty.
- Assertion of `reset` mid-stream takes effect immediately and is not clock-gated. After release, fetch restarts at RESET_PC as from power-up.

## Test plan
- **Sequential stream:** load words 0..7 with addi instructions, `instr_ready`=1. Expect `instr_pc` = 0, 4, …, 28 on consecutive cycles starting 2 cycles after reset release.
- **Backpressure:** drop `instr_ready` for 5 cycles mid-stream. Expect `instr`/`instr_pc` frozen, occupancy ≤ BUF_DEPTH, and no gaps or duplicates after release.
- **JAL:** word 2 = JAL +16 (32'h0100006F). Expect stream PCs 0, 4, 8, 24, 28 with no bubble.
- **Redirect:** assert `redirect_valid` with `redirect_pc`=32'h23 in cycle T. Expect `instr_valid`=0 in T+1, then `instr_pc`=32'h20 in T+2, with no older PCs after T.
- **Redirect plus JAL:** redirect in the same cycle a JAL returns. Expect the JAL and its target to be discarded and the stream to start at `redirect_pc`.
- **Wrap and reset:** with ADDR_WIDTH=6, a sequential run from 32'hF8 yields `instr_pc` FC then 100, and the instruction at 100 is word 0. Assert `reset` mid-run: `instr_valid` drops immediately and the stream restarts at RESET_PC.
